// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the memory-controller
//                arbiter: FSM state encoding, owner encoding and the
//                memory-controller length codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Owner encoding; OWN_IF doubles as the reset / "no owner" value
    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_LSB = 1'b1;

    // Memory-controller length codes (bit 2 selects sign extension)
    localparam logic [2:0] LEN_B  = 3'b000;
    localparam logic [2:0] LEN_H  = 3'b001;
    localparam logic [2:0] LEN_W  = 3'b010;
    localparam logic [2:0] LEN_BS = 3'b100;
    localparam logic [2:0] LEN_HS = 3'b101;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-way round-robin arbiter placing word-level requests from
//                the instruction-fetch unit (IF) and the load/store buffer
//                (LSB) onto the single byte-serial memory controller. The
//                granted request is held on the mc_* fields until mc_ready,
//                the result is captured and the owner gets a one-cycle done.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk_in, rst_in       clock, asynchronous active-low reset
//    rdy_in               global ready; low freezes every register
//    RoB_clear            synchronous flush, aborts the transaction in flight
//    if_req/if_addr       IF word-read request
//    if_done/if_data      IF completion pulse and fetched word
//    lsb_req/wr/len/addr/value   LSB request fields
//    lsb_done/lsb_data    LSB completion pulse and (extended) load data
//    mc_waiting/wr/len/addr/value  request to the memory controller
//    mc_ready/mc_result   memory-controller completion and read data
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        RoB_clear,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,

    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [2:0]  lsb_len,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_value,
    output logic        lsb_done,
    output logic [31:0] lsb_data,

    output logic        mc_waiting,
    output logic        mc_wr,
    output logic [2:0]  mc_len,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_value,
    input  logic        mc_ready,
    input  logic [31:0] mc_result
);

    state_t      r_state,      w_state;
    logic        r_owner,      w_owner;
    logic        r_last_owner, w_last_owner;
    logic        r_mc_waiting, w_mc_waiting;
    logic        r_mc_wr,      w_mc_wr;
    logic [2:0]  r_mc_len,     w_mc_len;
    logic [31:0] r_mc_addr,    w_mc_addr;
    logic [31:0] r_mc_value,   w_mc_value;
    logic        r_if_done,    w_if_done;
    logic        r_lsb_done,   w_lsb_done;
    logic [31:0] r_if_data,    w_if_data;
    logic [31:0] r_lsb_data,   w_lsb_data;

    // LSB wins when it is the only requester, or on a tie when IF was
    // served last; otherwise IF is granted.
    logic w_grant_lsb;
    assign w_grant_lsb = lsb_req & (~if_req | (r_last_owner == OWN_IF));

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state      = r_state;
        w_owner      = r_owner;
        w_last_owner = r_last_owner;
        w_mc_waiting = r_mc_waiting;
        w_mc_wr      = r_mc_wr;
        w_mc_len     = r_mc_len;
        w_mc_addr    = r_mc_addr;
        w_mc_value   = r_mc_value;
        w_if_data    = r_if_data;
        w_lsb_data   = r_lsb_data;
        // done bits are pulses: cleared unless set below
        w_if_done    = 1'b0;
        w_lsb_done   = 1'b0;

        if (RoB_clear) begin
            // Flush: drop the transaction and ignore same-cycle requests.
            // last_owner and the data registers keep their values.
            w_state      = IDLE;
            w_mc_waiting = 1'b0;
            w_owner      = OWN_IF;
        end else begin
            case (r_state)
                IDLE: begin
                    w_mc_waiting = 1'b0;
                    if (if_req | lsb_req) begin
                        w_state      = BUSY;
                        w_mc_waiting = 1'b1;
                        if (w_grant_lsb) begin
                            w_owner    = OWN_LSB;
                            w_mc_wr    = lsb_wr;
                            w_mc_len   = lsb_len;
                            w_mc_addr  = lsb_addr;
                            w_mc_value = lsb_value;
                        end else begin
                            w_owner    = OWN_IF;
                            w_mc_wr    = 1'b0;
                            w_mc_len   = LEN_W;
                            w_mc_addr  = if_addr;
                            w_mc_value = 32'h0;
                        end
                    end
                end
                BUSY: begin
                    if (mc_ready) begin
                        w_state      = RESP;
                        w_mc_waiting = 1'b0;
                        w_last_owner = r_owner;
                        if (r_owner == OWN_LSB) begin
                            w_lsb_data = mc_result;
                            w_lsb_done = 1'b1;
                        end else begin
                            w_if_data  = mc_result;
                            w_if_done  = 1'b1;
                        end
                    end
                end
                RESP: begin
                    // Requester updates its req during this cycle, so the
                    // following IDLE cycle never re-grants the served one.
                    w_state      = IDLE;
                    w_mc_waiting = 1'b0;
                end
                default: begin
                    w_state      = IDLE;
                    w_mc_waiting = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register; rdy_in low holds everything, reset overrides it
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= IDLE;
            r_owner      <= OWN_IF;
            r_last_owner <= OWN_IF;
            r_mc_waiting <= 1'b0;
            r_mc_wr      <= 1'b0;
            r_mc_len     <= 3'b000;
            r_mc_addr    <= 32'h0;
            r_mc_value   <= 32'h0;
            r_if_done    <= 1'b0;
            r_lsb_done   <= 1'b0;
            r_if_data    <= 32'h0;
            r_lsb_data   <= 32'h0;
        end else if (rdy_in) begin
            r_state      <= w_state;
            r_owner      <= w_owner;
            r_last_owner <= w_last_owner;
            r_mc_waiting <= w_mc_waiting;
            r_mc_wr      <= w_mc_wr;
            r_mc_len     <= w_mc_len;
            r_mc_addr    <= w_mc_addr;
            r_mc_value   <= w_mc_value;
            r_if_done    <= w_if_done;
            r_lsb_done   <= w_lsb_done;
            r_if_data    <= w_if_data;
            r_lsb_data   <= w_lsb_data;
        end
    end

    assign if_done    = r_if_done;
    assign if_data    = r_if_data;
    assign lsb_done   = r_lsb_done;
    assign lsb_data   = r_lsb_data;
    assign mc_waiting = r_mc_waiting;
    assign mc_wr      = r_mc_wr;
    assign mc_len     = r_mc_len;
    assign mc_addr    = r_mc_addr;
    assign mc_value   = r_mc_value;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A transaction-level
//                model (round-robin owner, expected fields, handshake timing)
//                runs at every falling edge alongside a latency-configurable
//                memory-controller model; directed scenarios are followed by
//                a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        RoB_clear;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req;
    logic        lsb_wr;
    logic [2:0]  lsb_len;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_value;
    logic        lsb_done;
    logic [31:0] lsb_data;
    logic        mc_waiting;
    logic        mc_wr;
    logic [2:0]  mc_len;
    logic [31:0] mc_addr;
    logic [31:0] mc_value;
    logic        mc_ready;
    logic [31:0] mc_result;

    mem_arbiter u_dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .RoB_clear (RoB_clear),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_data   (if_data),
        .lsb_req   (lsb_req),
        .lsb_wr    (lsb_wr),
        .lsb_len   (lsb_len),
        .lsb_addr  (lsb_addr),
        .lsb_value (lsb_value),
        .lsb_done  (lsb_done),
        .lsb_data  (lsb_data),
        .mc_waiting(mc_waiting),
        .mc_wr     (mc_wr),
        .mc_len    (mc_len),
        .mc_addr   (mc_addr),
        .mc_value  (mc_value),
        .mc_ready  (mc_ready),
        .mc_result (mc_result)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Bookkeeping and model state
    // ------------------------------------------------------------------
    int          n_checks = 0;
    int          n_errors = 0;

    logic        m_last;       // owner of the last completed transaction
    logic        m_owner;      // owner of the transaction in flight
    logic [67:0] m_snap;       // expected {wr,len,addr,value} while busy
    int          m_gap;        // effective cycles with mc_waiting low
    logic        p_wait, p_ifd, p_lsd;
    logic [134:0] p_all;
    bit          done_evt;
    logic        done_owner;

    int          ctl_cnt;
    int          ctl_lat;
    bit          ctl_rand_lat;
    logic [31:0] ctl_val;

    task automatic check_val(input string tag, input logic [159:0] obs,
                             input logic [159:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [134:0] all_outs();
        return {if_done, if_data, lsb_done, lsb_data, mc_waiting,
                mc_wr, mc_len, mc_addr, mc_value};
    endfunction

    task automatic model_reset();
        m_last   = 1'b0;
        m_owner  = 1'b0;
        m_snap   = '0;
        m_gap    = 2;
        p_wait   = 1'b0;
        p_ifd    = 1'b0;
        p_lsd    = 1'b0;
        p_all    = '0;
        done_evt = 1'b0;
        ctl_cnt  = 0;
        mc_ready = 1'b0;
    endtask

    // Observes the outcome of the rising edge that just passed, using the
    // inputs that were applied to it (they are still on the pins).
    task automatic monitor();
        logic own;
        if (!rst_in) return;
        if (!rdy_in) begin
            check_val("freeze", all_outs(), p_all);
        end else if (RoB_clear) begin
            check_val("flush", {mc_waiting, if_done, lsb_done}, 3'b000);
            m_gap = 2;
        end else if (p_wait) begin
            if (mc_ready) begin
                check_val("done", {mc_waiting, if_done, lsb_done},
                          {1'b0, ~m_owner, m_owner});
                if (m_owner == 1'b0)
                    check_val("if_data", if_data, mc_result);
                else if (!m_snap[67])
                    check_val("lsb_data", lsb_data, mc_result);
                m_last     = m_owner;
                done_owner = m_owner;
                done_evt   = 1'b1;
                m_gap      = 1;
            end else begin
                check_val("busy_hold",
                          {mc_waiting, if_done, lsb_done, mc_wr, mc_len, mc_addr, mc_value},
                          {3'b100, m_snap});
            end
        end else if (p_ifd || p_lsd) begin
            check_val("resp_idle", {mc_waiting, if_done, lsb_done}, 3'b000);
            m_gap++;
        end else if (if_req || lsb_req) begin
            own = (if_req && lsb_req) ? ~m_last : lsb_req;
            check_val("grant", {mc_waiting, if_done, lsb_done}, 3'b100);
            check_val("gap", (m_gap >= 2), 1'b1);
            if (own) begin
                check_val("grant_fields", {mc_wr, mc_len, mc_addr},
                          {lsb_wr, lsb_len, lsb_addr});
                check_val("grant_value", mc_value, lsb_value);
                m_snap = {lsb_wr, lsb_len, lsb_addr, lsb_value};
            end else begin
                check_val("grant_fields", {mc_wr, mc_len, mc_addr},
                          {1'b0, 3'b010, if_addr});
                m_snap = {1'b0, 3'b010, if_addr, mc_value};
            end
            m_owner = own;
        end else begin
            check_val("idle", {mc_waiting, if_done, lsb_done}, 3'b000);
            m_gap++;
        end
        p_all  = all_outs();
        p_wait = mc_waiting;
        p_ifd  = if_done;
        p_lsd  = lsb_done;
    endtask

    // Memory controller: raises mc_ready after ctl_lat cycles of waiting
    // and holds it until the request is withdrawn.
    task automatic controller();
        if (!rst_in || !mc_waiting) begin
            mc_ready = 1'b0;
            ctl_cnt  = 0;
        end else begin
            if (ctl_cnt == 0 && ctl_rand_lat) ctl_lat = $urandom_range(1, 4);
            ctl_cnt++;
            if (ctl_cnt >= ctl_lat && !mc_ready) begin
                mc_ready  = 1'b1;
                mc_result = ctl_val;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk_in);
        monitor();
        controller();
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        done_evt = 1'b0;
        while (!done_evt && n < bound) begin
            cyc();
            n++;
        end
        if (!done_evt) check_val("timeout", 1'b0, 1'b1);
    endtask

    logic [2:0] lens [5];
    logic       order [4];
    logic       exp_order [4];

    initial begin
        lens      = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
        rst_in = 1'b0; rdy_in = 1'b1; RoB_clear = 1'b0;
        if_req = 1'b0; if_addr = '0;
        lsb_req = 1'b0; lsb_wr = 1'b0; lsb_len = '0; lsb_addr = '0; lsb_value = '0;
        mc_result = '0; ctl_lat = 2; ctl_rand_lat = 1'b0; ctl_val = '0;
        done_owner = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_in);
        check_val("reset_outs", all_outs(), '0);
        rst_in = 1'b1;

        // Simultaneous requests after reset: LSB first, then alternate
        ctl_lat = 2; ctl_val = 32'h1111_0000;
        if_req = 1'b1; if_addr = 32'h400;
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 3'b010; lsb_addr = 32'h2000;
        for (int i = 0; i < 4; i++) begin
            ctl_val = ctl_val + 32'h1;
            wait_done(30);
            order[i] = done_owner;
            if (done_owner) lsb_addr = lsb_addr + 32'h4;
            else            if_addr  = if_addr + 32'h4;
        end
        for (int i = 0; i < 4; i++) check_val("rr_order", order[i], exp_order[i]);
        if_req = 1'b0;
        wait_done(30);
        check_val("rr_tail", done_owner, 1'b1);
        lsb_req = 1'b0;
        repeat (2) cyc();

        // IF fetch, 4-cycle controller
        ctl_lat = 4; ctl_val = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h100;
        cyc();
        check_val("if_mc_fields", {mc_waiting, mc_wr, mc_len, mc_addr},
                  {1'b1, 1'b0, 3'b010, 32'h100});
        wait_done(20);
        check_val("if_pulse", {if_done, lsb_done, if_data}, {2'b10, 32'hDEAD_BEEF});
        if_req = 1'b0;
        cyc();
        check_val("if_pulse_end", {if_done, mc_waiting}, 2'b00);
        cyc();

        // LSB byte store
        ctl_lat = 2; ctl_val = 32'h0;
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 3'b000;
        lsb_addr = 32'h30000; lsb_value = 32'hAB;
        cyc();
        check_val("st_value", mc_value, 32'hAB);
        wait_done(20);
        check_val("st_done", {if_done, lsb_done}, 2'b01);
        lsb_req = 1'b0;
        cyc();
        check_val("st_done_end", lsb_done, 1'b0);

        // LSB signed byte load
        ctl_lat = 1; ctl_val = 32'hFFFF_FF80;
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 3'b100; lsb_addr = 32'h30001;
        wait_done(20);
        check_val("ld_data", {lsb_done, lsb_data}, {1'b1, 32'hFFFF_FF80});
        lsb_req = 1'b0;
        repeat (2) cyc();

        // Flush in the second BUSY cycle, then re-issue
        ctl_lat = 6; ctl_val = 32'h0BAD_F00D;
        if_req = 1'b1; if_addr = 32'h200;
        cyc();
        cyc();
        RoB_clear = 1'b1;
        cyc();
        check_val("flush_state", {mc_waiting, if_done}, 2'b00);
        RoB_clear = 1'b0;
        ctl_lat = 2; ctl_val = 32'h1234_5678;
        wait_done(20);
        check_val("reissue", {if_done, if_data}, {1'b1, 32'h1234_5678});
        if_req = 1'b0;
        repeat (2) cyc();

        // rdy_in low during BUSY and during RESP
        ctl_lat = 3; ctl_val = 32'hCAFE_0001;
        if_req = 1'b1; if_addr = 32'h300;
        cyc();
        rdy_in = 1'b0;
        repeat (3) cyc();
        check_val("frz_busy", {mc_waiting, mc_addr}, {1'b1, 32'h300});
        rdy_in = 1'b1;
        wait_done(20);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_val("frz_resp", {if_done, if_data}, {1'b1, 32'hCAFE_0001});
        end
        rdy_in = 1'b1; if_req = 1'b0;
        cyc();
        check_val("frz_after", if_done, 1'b0);
        cyc();

        // Asynchronous reset in the middle of a transaction
        ctl_lat = 5; ctl_val = 32'h5555_AAAA;
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 3'b010;
        lsb_addr = 32'h40; lsb_value = 32'h77;
        cyc();
        cyc();
        #2 rst_in = 1'b0;
        #1 check_val("async_rst", all_outs(), '0);
        lsb_req = 1'b0;
        @(negedge clk_in);
        check_val("rst_hold", all_outs(), '0);
        model_reset();
        rst_in = 1'b1;

        // Randomized traffic
        ctl_rand_lat = 1'b1;
        for (int c = 0; c < 600; c++) begin
            done_evt = 1'b0;
            cyc();
            if (done_evt) begin
                if (done_owner == 1'b0) begin
                    if_req  = 1'($urandom_range(0, 1));
                    if_addr = $urandom & 32'hFFFF_FFFC;
                end else begin
                    lsb_req   = 1'($urandom_range(0, 1));
                    lsb_wr    = 1'($urandom_range(0, 1));
                    lsb_len   = lens[$urandom_range(0, 4)];
                    lsb_addr  = $urandom;
                    lsb_value = $urandom;
                end
            end
            if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req  = 1'b1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsb_req && $urandom_range(0, 3) == 0) begin
                lsb_req   = 1'b1;
                lsb_wr    = 1'($urandom_range(0, 1));
                lsb_len   = lens[$urandom_range(0, 4)];
                lsb_addr  = $urandom;
                lsb_value = $urandom;
            end
            rdy_in    = ($urandom_range(0, 9) != 0);
            RoB_clear = ($urandom_range(0, 29) == 0);
            ctl_val   = $urandom;
        end
        rdy_in = 1'b1; RoB_clear = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
